// File: rtl/sseg_dec_scan_n_pkg.sv
// Shared glyphs, FSM encoding and BCD-to-segment lookup for the multiplexed
// decimal display driver. Glyph bit order is a..g, active-low.
package sseg_dec_scan_n_pkg;

   typedef logic [0:6] seg_t;

   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Non-decimal codes render as blank.
   function automatic seg_t bcd_to_seg(input logic [3:0] d);
      seg_t s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sseg_dec_scan_n_bin2bcd_seq.sv
// Sequential double-dabble: captures bin on load, converts in W cycles,
// commits BCD digits and a sticky overflow flag with a one-cycle done pulse.
module bin2bcd_seq
   import sseg_dec_scan_n_pkg::*;
#(
   parameter int unsigned W  = 8,
   parameter int unsigned ND = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    bin,
   input  logic            load,
   output logic            busy,
   output logic            done,
   output logic [4*ND-1:0] bcd,
   output logic            ovf
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned BW = 4 * ND;

   state_t         state, state_nxt;
   logic           busy_nxt, done_nxt;
   logic [W-1:0]   sh;
   logic [BW-1:0]  acc, acc_adj;
   logic [CW-1:0]  cnt;
   logic           flag;

   // Add-3 correction on every nibble that is 5 or more.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < int'(ND); i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE:   if (load) state_nxt = ST_CONV;
         ST_CONV:   if (cnt == CW'(W - 1)) state_nxt = ST_COMMIT;
         ST_COMMIT: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end
         default:   state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Shift datapath; a one leaving the top nibble means the value needs more digits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh   <= '0;
         acc  <= '0;
         cnt  <= '0;
         flag <= 1'b0;
         bcd  <= '0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (load) begin
               sh   <= bin;
               acc  <= '0;
               cnt  <= '0;
               flag <= 1'b0;
            end
            ST_CONV: begin
               acc  <= {acc_adj[BW-2:0], sh[W-1]};
               flag <= flag | acc_adj[BW-1];
               sh   <= sh << 1;
               cnt  <= cnt + CW'(1);
            end
            ST_COMMIT: begin
               bcd <= acc;
               ovf <= flag;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sseg_dec_scan_n.sv
// N-digit multiplexed common-anode decimal display driver.
// Optional leading-zero blanking when SSEG_LZB_EN is defined.
module sseg_dec_scan_n
   import sseg_dec_scan_n_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned ND       = 4,
   parameter int unsigned DIV_BITS = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  bin,
   input  logic          load,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic [0:6]    sseg,
   output logic [ND-1:0] an
);

   localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;

   logic [4*ND-1:0]     bcd;
   logic [DIV_BITS-1:0] div;
   logic                tick;
   logic [IW-1:0]       idx, idx_nxt;
   logic [3:0]          digit;
   logic                blank;
   seg_t                glyph;
   logic [ND-1:0]       an_nxt;

   bin2bcd_seq #(.W(W), .ND(ND)) u_conv (
      .clk  (clk),
      .rst  (rst),
      .bin  (bin),
      .load (load),
      .busy (busy),
      .done (done),
      .bcd  (bcd),
      .ovf  (ovf)
   );

   assign tick    = &div;
   assign idx_nxt = (idx == IW'(ND - 1)) ? '0 : idx + IW'(1);
   assign an_nxt  = ~(ND'(1) << idx);

   always_comb begin
      digit = '0;
      for (int i = 0; i < int'(ND); i++) begin
         if (IW'(i) == idx) digit = bcd[4*i +: 4];
      end
   end

`ifdef SSEG_LZB_EN
   logic [IW-1:0] msd;

   // Highest non-zero digit; digit 0 is never blanked so zero reads "0".
   always_comb begin
      msd = '0;
      for (int i = 0; i < int'(ND); i++) begin
         if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
      end
   end
   assign blank = (idx > msd);
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      glyph = bcd_to_seg(digit);
      if (blank) glyph = SEG_BLANK;
      if (ovf)   glyph = SEG_DASH;
   end

   // Free-running divider; the terminal count advances the scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div  <= '0;
         idx  <= '0;
         an   <= '1;
         sseg <= SEG_BLANK;
      end else begin
         div <= div + DIV_BITS'(1);
         if (tick) begin
            idx  <= idx_nxt;
            an   <= an_nxt;
            sseg <= glyph;
         end
      end
   end

endmodule

// File: tb/tb_sseg_dec_scan_n.sv
// Self-checking bench for sseg_dec_scan_n (W=8, ND=4 and ND=2, DIV_BITS=2).
// Honours SSEG_LZB_EN in its expected glyphs.
module tb_sseg_dec_scan_n;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst, load, load2;
   logic [7:0] bin, bin2;
   logic       busy, done, ovf, busy2, done2, ovf2;
   logic [0:6] sseg, sseg2;
   logic [3:0] an;
   logic [1:0] an2;

   typedef struct { logic [7:0] v; logic [15:0] bcd; } vec_t;
   typedef struct { int v; int due; } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0, cyc = 0, free_at = 0, last_val = 0;
   vec_t vecs[8];

   always #5 clk = ~clk;

   sseg_dec_scan_n #(.W(8), .ND(4), .DIV_BITS(2)) u_dut (
      .clk(clk), .rst(rst), .bin(bin), .load(load), .busy(busy), .done(done),
      .ovf(ovf), .sseg(sseg), .an(an));

   sseg_dec_scan_n #(.W(8), .ND(2), .DIV_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .bin(bin2), .load(load2), .busy(busy2), .done(done2),
      .ovf(ovf2), .sseg(sseg2), .an(an2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
   endfunction

   // Acceptance model: a load is taken only when the converter is idle.
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         q.delete();
         free_at = 0;
      end else if (load && cyc >= free_at) begin
         q.push_back('{int'(bin), cyc + W + 1});
         free_at  = cyc + W + 2;
         last_val = int'(bin);
      end
   end

   // Scoreboard: busy and done timing against the pending captures.
   always @(negedge clk) begin
      bit de, be;
      if (!rst) q.delete();
      de = (q.size() > 0) && (q[0].due == cyc);
      be = (q.size() > 0) && (q[0].due > cyc);
      chk("busy", 32'(busy), 32'(be));
      chk("done", 32'(done), 32'(de));
      if (de) begin
         chk("ovf_commit", 32'(ovf), 32'(0));
         void'(q.pop_front());
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while (q.size() > 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL idle_timeout: %0d commits still pending after %0d cycles", q.size(), budget);
      end
   endtask

   task automatic check_disp(input bit sel, input logic [15:0] bcd, input bit ov, input string tag);
      int nd, msd;
      nd  = sel ? 2 : 4;
      msd = 0;
      for (int i = 0; i < nd; i++) if (bcd[4*i +: 4] != 4'd0) msd = i;
      repeat (6) @(posedge clk);
      for (int i = 0; i < nd; i++) begin
         logic [7:0] tgt, aw;
         logic [6:0] sw, ex;
         int n;
         tgt = ~(8'(1) << i);
         n   = 0;
         @(negedge clk); #1;
         aw = sel ? {6'h3F, an2} : {4'hF, an};
         while (aw !== tgt && n < 64) begin
            @(negedge clk); #1;
            aw = sel ? {6'h3F, an2} : {4'hF, an};
            n++;
         end
         ex = ov ? 7'b1111110 : glyph(bcd[4*i +: 4]);
`ifdef SSEG_LZB_EN
         if (!ov && i > msd) ex = 7'b1111111;
`endif
         sw = sel ? sseg2 : sseg;
         chk($sformatf("%s_d%0d", tag, i), {16'h0, aw, 1'b0, sw}, {16'h0, tgt, 1'b0, ex});
      end
   endtask

   task automatic load_one(input logic [7:0] v);
      @(posedge clk); #1;
      bin  = v;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      bin  = ~v;
   endtask

   task automatic load_dut2(input logic [7:0] v, input bit ov, input logic [15:0] bcd, input string tag);
      int n = 0;
      @(posedge clk); #1;
      bin2  = v;
      load2 = 1'b1;
      @(posedge clk); #1;
      load2 = 1'b0;
      while (done2 !== 1'b1 && n < 30) begin
         @(negedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, 32'(done2), 32'(1));
      chk({tag, "_ovf"}, 32'(ovf2), 32'(ov));
      check_disp(1'b1, bcd, ov, tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'd173, 16'h0173};
      vecs[1] = '{8'd0,   16'h0000};
      vecs[2] = '{8'd255, 16'h0255};
      vecs[3] = '{8'd9,   16'h0009};
      vecs[4] = '{8'd10,  16'h0010};
      vecs[5] = '{8'd128, 16'h0128};
      vecs[6] = '{8'd99,  16'h0099};
      vecs[7] = '{8'd1,   16'h0001};

      rst = 1'b0; load = 1'b0; load2 = 1'b0; bin = '0; bin2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_an", 32'(an), 32'(4'hF));
      chk("rst_sseg", 32'(sseg), 32'(7'h7F));
      chk("rst_ovf", 32'(ovf), 32'(0));
      chk("rst_an2", 32'(an2), 32'(2'h3));

      // Divider starts at 0, so the first tick lands on the fourth edge after release.
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_tick_an", 32'(an), 32'(4'hF));
      chk("pre_tick_sseg", 32'(sseg), 32'(7'h7F));
      @(posedge clk);
      @(negedge clk);
      chk("first_tick_an", 32'(an), 32'(4'b1110));
      chk("first_tick_sseg", 32'(sseg), 32'(7'b0000001));

      for (int i = 0; i < 8; i++) begin
         load_one(vecs[i].v);
         wait_idle(40);
         check_disp(1'b0, vecs[i].bcd, 1'b0, $sformatf("vec%0d", i));
      end

      load_dut2(8'd100, 1'b1, 16'h0000, "nd2_100");
      load_dut2(8'd99,  1'b0, 16'h0099, "nd2_99");
      chk("nd2_busy_idle", 32'(busy2), 32'(0));

      // Load held high with a moving value: one capture every W+2 cycles.
      @(posedge clk); #1;
      bin  = 8'd40;
      load = 1'b1;
      repeat (3 * (W + 2) + 3) begin
         @(posedge clk); #1;
         bin = bin + 8'd1;
      end
      load = 1'b0;
      wait_idle(40);
      check_disp(1'b0, to_bcd(last_val), 1'b0, "stream");

      // Reset four cycles into a conversion aborts it and clears the display.
      load_one(8'd200);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_an", 32'(an), 32'(4'hF));
      chk("abort_sseg", 32'(sseg), 32'(7'h7F));
      @(posedge clk); #1 rst = 1'b1;
      repeat (W + 4) @(posedge clk);
      check_disp(1'b0, 16'h0000, 1'b0, "abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
